// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, PC state encoding, PC step size.
// Used by pc_update_unit and branch_target_calc.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [5:0] OP_BR   = 6'b001100;
   localparam logic [5:0] OP_BZ   = 6'b001111;
   localparam logic [5:0] OP_BMI  = 6'b001101;
   localparam logic [5:0] OP_BPL  = 6'b001010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic is_branch_op(
      input logic [5:0] op
   );
      return (op == OP_BR)  || (op == OP_BZ) ||
             (op == OP_BMI) || (op == OP_BPL);
   endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target: pc + 4 + (sign-extended word offset << 2), modulo 2^32.
// Pure combinational; registers live in pc_update_unit.
module branch_target_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] offset,
   output logic [31:0] target
);

   logic [31:0] byte_off;

   assign byte_off = {{4{offset[25]}}, offset, 2'b00};
   assign target   = pc + PC_STEP + byte_off;

endmodule

// File: rtl/pc_update_unit.sv
// Program counter update unit: IDLE -> RUN -> HALT sequencing and PC advance.
// Define PC_BRANCH_STATS_EN to add saturating branch/taken counters.
module pc_update_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic [5:0]  opcode,
   input  logic        branch_taken,
   input  logic [25:0] offset,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        flush,
   output logic        halted
`ifdef PC_BRANCH_STATS_EN
   ,
   output logic [15:0] branch_count,
   output logic [15:0] taken_count
`endif
);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        flush_q;
   logic        flush_d;
   logic [31:0] target;
   logic        br_op;
   logic        is_halt;
   logic        take;

   branch_target_calc u_btc (
      .pc     (pc_q),
      .offset (offset),
      .target (target)
   );

   assign br_op   = is_branch_op(opcode);
   assign is_halt = (opcode == OP_HALT);
   assign take    = br_op && branch_taken;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      unique case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            if (step) begin
               // halt opcode is outside the branch group, so arms never overlap
               unique case (1'b1)
                  is_halt: state_d = ST_HALT;
                  take: begin
                     pc_d    = target;
                     flush_d = 1'b1;
                  end
                  default: pc_d = pc_q + PC_STEP;
               endcase
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= 32'h0000_0000;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
      end
   end

   assign pc       = pc_q;
   assign pc_valid = (state_q == ST_RUN);
   assign flush    = flush_q;
   assign halted   = (state_q == ST_HALT);

`ifdef PC_BRANCH_STATS_EN
   logic cnt_en;

   assign cnt_en = (state_q == ST_RUN) && step && br_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count <= 16'h0000;
         taken_count  <= 16'h0000;
      end else if (cnt_en) begin
         if (branch_count != 16'hFFFF)
            branch_count <= branch_count + 16'd1;
         if (branch_taken && (taken_count != 16'hFFFF))
            taken_count <= taken_count + 16'd1;
      end
   end
`endif

endmodule
